// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: FSM state encoding and defaults shared by the arbiter and its storage
package shared_reg_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, HOLD} state_t;
  localparam int HOLD_MAX_DEF = 3;
endpackage

// File: rtl/shared_reg.sv
// shared_reg: WIDTH-bit shared register with load enable and complement output
module shared_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (en) q <= d;
  assign qbar = ~q;
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter granting NREQ requesters access to one shared register
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  state_t state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [IW-1:0] idx, idx_n, rr_ptr, rr_n, win, j, nxt;
  logic [CW-1:0] hold_cnt, cnt_n;
  logic found, last, load;
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  assign nxt  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  assign last = hold_cnt == CW'(HOLD_MAX - 1);
  assign ack  = state == ACCESS;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    idx_n = idx;
    rr_n = rr_ptr;
    cnt_n = hold_cnt;
    load = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        gnt_n = NREQ'(1) << win;
        idx_n = win;
        state_n = GRANT;
      end
      GRANT: if (req[idx]) begin
        cnt_n = '0;
        state_n = ACCESS;
      end else begin
        gnt_n = '0;
        state_n = IDLE;
      end
      ACCESS: begin
        load = wr[idx];
        state_n = HOLD;
      end
      HOLD: if (!req[idx] || last) begin
        gnt_n = '0;
        rr_n = nxt;
        state_n = IDLE;
      end else if (wr[idx]) state_n = ACCESS;
      else cnt_n = hold_cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      gnt <= '0;
      idx <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      idx <= idx_n;
      rr_ptr <= rr_n;
      hold_cnt <= cnt_n;
    end
  shared_reg #(.WIDTH(WIDTH)) u_reg (
    .clock(clock),
    .reset(reset),
    .en(load),
    .d(wdata[idx*WIDTH +: WIDTH]),
    .q(q),
    .qbar(qbar)
  );
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
  logic clock = 0;
  logic reset;
  logic [3:0] req, wr, gnt;
  logic [31:0] wdata;
  logic ack, busy;
  logic [7:0] q, qbar;
  int errs = 0, n = 0;

  shared_reg_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .qbar(qbar), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    reset = 0; req = 0; wr = 0; wdata = 0;
    tick;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    reset = 1;
    // load A5, then reset clears it
    req = 4'b0001; wr = 4'b0001; wdata[7:0] = 8'hA5;
    tick;
    chk("a5_gnt", gnt, 4'b0001);
    chk("a5_busy", busy, 1);
    chk("a5_ack0", ack, 0);
    tick;
    chk("a5_ack", ack, 1);
    tick;
    chk("a5_q", q, 8'hA5);
    chk("a5_qbar", qbar, 8'h5A);
    reset = 0; req = 0; wr = 0;
    #1;
    chk("a5rst_q", q, 8'h00);
    chk("a5rst_qbar", qbar, 8'hFF);
    chk("a5rst_gnt", gnt, 4'b0000);
    chk("a5rst_busy", busy, 0);
    tick;
    reset = 1;
    // single write by requester 1
    req = 4'b0010; wr = 4'b0010; wdata[15:8] = 8'h3C;
    tick;
    chk("w1_gnt", gnt, 4'b0010);
    chk("w1_ack0", ack, 0);
    tick;
    chk("w1_ack", ack, 1);
    tick;
    chk("w1_q", q, 8'h3C);
    chk("w1_qbar", qbar, 8'hC3);
    chk("w1_ackoff", ack, 0);
    req = 0; wr = 0;
    tick;
    chk("w1_rel", gnt, 4'b0000);
    chk("w1_idle", busy, 0);
    // abort in GRANT: rr_ptr=2 kept
    req = 4'b0100; wr = 4'b0100; wdata[23:16] = 8'h77;
    tick;
    chk("ab_gnt", gnt, 4'b0100);
    req = 0;
    tick;
    chk("ab_gnt0", gnt, 4'b0000);
    chk("ab_ack", ack, 0);
    chk("ab_busy", busy, 0);
    req = 4'b1101; wr = 0;
    tick;
    chk("ab_q", q, 8'h3C);
    chk("ab_regnt", gnt, 4'b0100);
    req = 0;
    tick;
    chk("ab2_gnt0", gnt, 4'b0000);
    // reset during HOLD of requester 1
    req = 4'b0010;
    tick;
    chk("rh_gnt", gnt, 4'b0010);
    tick;
    chk("rh_ack", ack, 1);
    tick;
    chk("rh_hold", gnt, 4'b0010);
    chk("rh_busy", busy, 1);
    chk("rh_q", q, 8'h3C);
    reset = 0; req = 4'b1111;
    #1;
    chk("rh_gnt0", gnt, 4'b0000);
    chk("rh_ack0", ack, 0);
    chk("rh_busy0", busy, 0);
    #4;
    reset = 1;
    // round robin with all requesting: 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      tick;
      chk($sformatf("rr%0d_gnt", g), gnt, 4'b0001 << (g % 4));
      chk($sformatf("rr%0d_ack0", g), ack, 0);
      tick;
      chk($sformatf("rr%0d_ack", g), ack, 1);
      for (int h = 0; h < 3; h++) begin
        tick;
        chk($sformatf("rr%0d_hold%0d", g, h), gnt, 4'b0001 << (g % 4));
        chk($sformatf("rr%0d_hack%0d", g, h), ack, 0);
      end
      tick;
      chk($sformatf("rr%0d_rel", g), gnt, 4'b0000);
      chk($sformatf("rr%0d_idle", g), busy, 0);
    end
    // two writes in one HOLD
    req = 4'b0001; wr = 4'b0001; wdata[7:0] = 8'h11;
    tick;
    chk("dw_gnt", gnt, 4'b0001);
    tick;
    chk("dw_ack1", ack, 1);
    tick;
    chk("dw_q1", q, 8'h11);
    chk("dw_noack", ack, 0);
    wdata[7:0] = 8'h22;
    tick;
    chk("dw_ack2", ack, 1);
    chk("dw_gnt2", gnt, 4'b0001);
    tick;
    chk("dw_q2", q, 8'h22);
    chk("dw_qbar2", qbar, 8'hDD);
    wr = 0;
    tick;
    chk("dw_h1", gnt, 4'b0001);
    tick;
    chk("dw_h2", gnt, 4'b0001);
    tick;
    chk("dw_rel", gnt, 4'b0000);
    chk("dw_idle", busy, 0);
    chk("dw_qkeep", q, 8'h22);
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
